fmac_align_stage: RTL and testbench
===================================

Name: fmac_align_stage

Overview:
Pipeline stage directly downstream of the FMAC operand preprocessor. It consumes the unpacked sign/exponent/mantissa fields and the class flags of a, b and c for the operation a*b+c. Per operation it resolves special cases and computes the product exponent, effective operation and addend alignment shift, then registers the result behind a valid/ready handshake. A two-entry elastic buffer holds results so the multiplier-array stage can stall without a combinational ready path.

Parameters:
C_EXP, 8 (from fpu_defs_fmac), exponent width
C_MANT, 23 (from fpu_defs_fmac), stored mantissa width
C_BIAS, 127, exponent bias
C_SHIFT_W, 7, alignment shift width

Ports:
Clk_CI  in  1  clock
Rst_RI  in  1  reset, asynchronous, active-high
Flush_SI  in  1  drop all buffered operations
Valid_SI  in  1  upstream operands valid
Ready_SO  out  1  stage can accept
Sign_a_DI/Sign_b_DI/Sign_c_DI  in  1 each  operand signs
Exp_a_DI/Exp_b_DI/Exp_c_DI  in  C_EXP each  exponents (denormal already forced to 1)
Mant_a_DI/Mant_b_DI/Mant_c_DI  in  C_MANT+1 each  mantissas with hidden bit
Inf_*_SI, Zero_*_SI, NaN_*_SI, DeN_*_SI  in  1 each (a,b,c)  class flags
Valid_SO  out  1  result valid
Ready_SI  in  1  downstream accepts
Mant_a_DO/Mant_b_DO/Mant_c_DO  out  C_MANT+1 each  registered mantissas
Exp_prod_DO  out  C_EXP+2  signed Exp_a+Exp_b-C_BIAS
Shift_DO  out  C_SHIFT_W  addend right-shift amount
Sign_prod_DO  out  1  Sign_a xor Sign_b
Sign_c_DO  out  1  addend sign
Sub_SO  out  1  effective subtraction (Sign_prod != Sign_c)
Special_SO  out  1  result fully determined, datapath bypass
Special_res_DO  out  C_EXP+C_MANT+1  special result word
NV_SO  out  1  invalid-operation flag

Behaviour:
- Reset: Valid_SO=0, Ready_SO=1, all data outputs 0, FSM EMPTY.
- Transfer in: Valid_SI & Ready_SO; out: Valid_SO & Ready_SI. Outputs stable while Valid_SO & ~Ready_SI.
- Compute combinationally on inputs, capture into main reg (or skid reg); latency 1 cycle, throughput 1/cycle.
- d = Exp_a+Exp_b-C_BIAS-Exp_c (signed, C_EXP+3 bits); Shift_DO = clamp(d+C_MANT+3, 0, 3*C_MANT+5=74).
- Special priority: any NaN -> 0x7FC00000, NV=1 iff any NaN has mantissa MSB=0; Inf*0 -> qNaN, NV=1; product Inf and Inf_c with Sub -> qNaN, NV=1; product Inf -> {Sign_prod,inf}; Inf_c -> {Sign_c,inf}; product zero and Zero_c -> zero, sign=Sign_prod if equal to Sign_c else +0 (RNE only); otherwise Special_SO=0, Special_res_DO=0, NV=0.
- FSM (skid variant): EMPTY (main invalid) -accept-> BUSY; BUSY: accept&drain stays BUSY (main reloaded), drain only -> EMPTY, accept&~drain -> FULL (incoming into skid); FULL: Ready_SO=0, drain -> BUSY (skid moves to main). Ready_SO is a register = (next state != FULL).
- Flush_SI: next cycle state EMPTY, Valid_SO=0, Ready_SO=1; flush beats a same-cycle accept (operation lost).
- Reset mid-operation: immediate return to reset values.

Optional Feature:
FMAC_ALIGN_SKID_EN: defined -> two-entry EMPTY/BUSY/FULL buffer above, Ready_SO registered. Undefined -> single main register, no skid, Ready_SO = ~Valid_SO | Ready_SI (combinational), states EMPTY/BUSY only; all other behaviour identical.

Decomposition:
- Add to fpu_defs_fmac: C_BIAS, C_SHIFT_W, C_SHIFT_MAX=74, C_QNAN=32'h7FC00000, packed struct align_res_t (all registered outputs), enum align_state_t {EMPTY,BUSY,FULL}.
- Sub-module fmac_special_case: purely combinational special/NV resolution; top holds exponent math, FSM and registers.

Test Plan:
- a=0x3F800000, b=0x40000000, c=0x3F800000, Ready_SI=1 -> next cycle Valid_SO=1, Exp_prod=128, Shift=27, Sub=0, Special=0.
- a=+Inf, b=+0, c=1.0 -> Special=1, Special_res=0x7FC00000, NV=1; a=sNaN 0x7F800001 -> qNaN, NV=1; a=qNaN 0x7FC00001 -> NV=0.
- a=+Inf, b=1.0, c=-Inf -> qNaN, NV=1; c=+Inf -> 0x7F800000, NV=0; a=-0,b=1.0,c=+0 -> 0x00000000.
- Shift clamps: Exp_a=Exp_b=1, Exp_c=254 -> 0; Exp_a=Exp_b=254, Exp_c=1 -> 74.
- Skid: hold Ready_SI=0, send 3 ops -> 2 accepted, Ready_SO=0 after second; release -> ops drain in order, none lost/duplicated, Ready_SO back to 1.
- Flush with FULL and Valid_SI=1 same cycle -> next cycle Valid_SO=0, Ready_SO=1, no output of any of the 3 ops; async reset mid-stream -> outputs to reset values immediately.

Source files
------------

// File: rtl/fmac_align_stage_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fmac_align_stage_pkg                                          |
// | Purpose  : Shared definitions for the FMAC alignment stage (the          |
// |            fpu_defs_fmac constant set plus align-stage additions).       |
// | Contents : field widths, bias, shift limits, canonical qNaN, the         |
// |            registered result record and the buffer state encoding.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package fmac_align_stage_pkg;

  localparam int C_EXP       = 8;
  localparam int C_MANT      = 23;
  localparam int C_BIAS      = 127;
  localparam int C_SHIFT_W   = 7;
  localparam int C_SHIFT_MAX = 3 * C_MANT + 5;

  localparam logic [C_EXP+C_MANT:0] C_QNAN = 32'h7FC0_0000;

  // Everything the stage registers and presents downstream.
  typedef struct packed {
    logic [C_MANT:0]         mant_a;
    logic [C_MANT:0]         mant_b;
    logic [C_MANT:0]         mant_c;
    logic [C_EXP+1:0]        exp_prod;
    logic [C_SHIFT_W-1:0]    shift;
    logic                    sign_prod;
    logic                    sign_c;
    logic                    sub;
    logic                    special;
    logic [C_EXP+C_MANT:0]   special_res;
    logic                    nv;
  } align_res_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } align_state_t;

  // Signed infinity in the stored format.
  function automatic logic [C_EXP+C_MANT:0] inf_word(input logic sign);
    return {sign, {C_EXP{1'b1}}, {C_MANT{1'b0}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fmac_align_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fmac_align_in_if / fmac_align_out_if                          |
// | Purpose  : Handshake bundles of the FMAC alignment stage.                |
// |            fmac_align_in_if  : unpacked operands a, b, c + class flags,  |
// |                                Valid_SI / Ready_SO.                      |
// |            fmac_align_out_if : aligned operation record,                 |
// |                                Valid_SO / Ready_SI.                      |
// |            master drives the payload, slave drives the ready.            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface fmac_align_in_if;
  import fmac_align_stage_pkg::*;

  logic              Valid_SI;
  logic              Ready_SO;
  logic              Sign_a_DI, Sign_b_DI, Sign_c_DI;
  logic [C_EXP-1:0]  Exp_a_DI, Exp_b_DI, Exp_c_DI;
  logic [C_MANT:0]   Mant_a_DI, Mant_b_DI, Mant_c_DI;
  logic              Inf_a_SI, Inf_b_SI, Inf_c_SI;
  logic              Zero_a_SI, Zero_b_SI, Zero_c_SI;
  logic              NaN_a_SI, NaN_b_SI, NaN_c_SI;
  logic              DeN_a_SI, DeN_b_SI, DeN_c_SI;

  modport master (
    output Valid_SI, Sign_a_DI, Sign_b_DI, Sign_c_DI,
           Exp_a_DI, Exp_b_DI, Exp_c_DI, Mant_a_DI, Mant_b_DI, Mant_c_DI,
           Inf_a_SI, Inf_b_SI, Inf_c_SI, Zero_a_SI, Zero_b_SI, Zero_c_SI,
           NaN_a_SI, NaN_b_SI, NaN_c_SI, DeN_a_SI, DeN_b_SI, DeN_c_SI,
    input  Ready_SO
  );

  modport slave (
    input  Valid_SI, Sign_a_DI, Sign_b_DI, Sign_c_DI,
           Exp_a_DI, Exp_b_DI, Exp_c_DI, Mant_a_DI, Mant_b_DI, Mant_c_DI,
           Inf_a_SI, Inf_b_SI, Inf_c_SI, Zero_a_SI, Zero_b_SI, Zero_c_SI,
           NaN_a_SI, NaN_b_SI, NaN_c_SI, DeN_a_SI, DeN_b_SI, DeN_c_SI,
    output Ready_SO
  );
endinterface

interface fmac_align_out_if;
  import fmac_align_stage_pkg::*;

  logic                    Valid_SO;
  logic                    Ready_SI;
  logic [C_MANT:0]         Mant_a_DO, Mant_b_DO, Mant_c_DO;
  logic [C_EXP+1:0]        Exp_prod_DO;
  logic [C_SHIFT_W-1:0]    Shift_DO;
  logic                    Sign_prod_DO;
  logic                    Sign_c_DO;
  logic                    Sub_SO;
  logic                    Special_SO;
  logic [C_EXP+C_MANT:0]   Special_res_DO;
  logic                    NV_SO;

  modport master (
    output Valid_SO, Mant_a_DO, Mant_b_DO, Mant_c_DO, Exp_prod_DO, Shift_DO,
           Sign_prod_DO, Sign_c_DO, Sub_SO, Special_SO, Special_res_DO, NV_SO,
    input  Ready_SI
  );

  modport slave (
    input  Valid_SO, Mant_a_DO, Mant_b_DO, Mant_c_DO, Exp_prod_DO, Shift_DO,
           Sign_prod_DO, Sign_c_DO, Sub_SO, Special_SO, Special_res_DO, NV_SO,
    output Ready_SI
  );
endinterface
`default_nettype wire

// File: rtl/fmac_align_stage_special.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fmac_special_case                                             |
// | Purpose  : Combinational special-operand resolution for a*b+c.           |
// |            Decides whether the result is fully determined by the         |
// |            operand classes, supplies that result and the invalid flag.   |
// | Ports    : i_sign_prod, i_sign_c, i_sub  - product/addend signs, eff.sub |
// |            i_inf_*, i_zero_*, i_nan_*    - class flags of a, b, c        |
// |            i_quiet_*                     - mantissa MSB (quiet NaN bit)  |
// |            o_special, o_special_res, o_nv                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module fmac_special_case
  import fmac_align_stage_pkg::*;
(
  input  logic                  i_sign_prod,
  input  logic                  i_sign_c,
  input  logic                  i_sub,
  input  logic                  i_inf_a,
  input  logic                  i_inf_b,
  input  logic                  i_inf_c,
  input  logic                  i_zero_a,
  input  logic                  i_zero_b,
  input  logic                  i_zero_c,
  input  logic                  i_nan_a,
  input  logic                  i_nan_b,
  input  logic                  i_nan_c,
  input  logic                  i_quiet_a,
  input  logic                  i_quiet_b,
  input  logic                  i_quiet_c,
  output logic                  o_special,
  output logic [C_EXP+C_MANT:0] o_special_res,
  output logic                  o_nv
);

  logic w_any_nan;
  logic w_any_snan;
  logic w_inf_times_zero;
  logic w_prod_inf;
  logic w_prod_zero;

  assign w_any_nan        = i_nan_a | i_nan_b | i_nan_c;
  assign w_any_snan       = (i_nan_a & ~i_quiet_a) | (i_nan_b & ~i_quiet_b) |
                            (i_nan_c & ~i_quiet_c);
  assign w_inf_times_zero = (i_inf_a & i_zero_b) | (i_zero_a & i_inf_b);
  // Inf*0 has already been excluded when these are consulted.
  assign w_prod_inf       = i_inf_a | i_inf_b;
  assign w_prod_zero      = i_zero_a | i_zero_b;

  always_comb begin
    o_special     = 1'b1;
    o_special_res = '0;
    o_nv          = 1'b0;
    if (w_any_nan) begin
      o_special_res = C_QNAN;
      o_nv          = w_any_snan;
    end else if (w_inf_times_zero) begin
      o_special_res = C_QNAN;
      o_nv          = 1'b1;
    end else if (w_prod_inf && i_inf_c && i_sub) begin
      o_special_res = C_QNAN;
      o_nv          = 1'b1;
    end else if (w_prod_inf) begin
      o_special_res = inf_word(i_sign_prod);
    end else if (i_inf_c) begin
      o_special_res = inf_word(i_sign_c);
    end else if (w_prod_zero && i_zero_c) begin
      // Exact zero sum: keeps the common sign, otherwise +0 (round-to-nearest).
      o_special_res = {i_sign_prod & i_sign_c, {(C_EXP+C_MANT){1'b0}}};
    end else begin
      o_special     = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fmac_align_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fmac_align_stage                                              |
// | Purpose  : FMAC alignment stage. Per operation a*b+c computes product    |
// |            exponent, effective subtraction, addend right-shift and the   |
// |            special-case result, then registers it behind valid/ready.    |
// | Ports    : Clk_CI, Rst_RI (async, active-high), Flush_SI                 |
// |            in_bus  (fmac_align_in_if.slave)  - operands from preproc.    |
// |            out_bus (fmac_align_out_if.master)- record to multiplier      |
// | Config   : FMAC_ALIGN_SKID_EN defined  -> two-entry buffer               |
// |            (EMPTY/BUSY/FULL), registered Ready_SO.                       |
// |            undefined -> single register, Ready_SO = ~Valid_SO|Ready_SI.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module fmac_align_stage
  import fmac_align_stage_pkg::*;
(
  input  logic             Clk_CI,
  input  logic             Rst_RI,
  input  logic             Flush_SI,
  fmac_align_in_if.slave   in_bus,
  fmac_align_out_if.master out_bus
);

  localparam logic [1:0] c_ST_EMPTY = EMPTY;
  localparam logic [1:0] c_ST_BUSY  = BUSY;
`ifdef FMAC_ALIGN_SKID_EN
  localparam logic [1:0] c_ST_FULL  = FULL;
`endif

  localparam logic signed [C_EXP+2:0] c_BIAS_EXT  = (C_EXP+3)'(C_BIAS);
  localparam logic signed [C_EXP+2:0] c_SHIFT_OFF = (C_EXP+3)'(C_MANT+3);
  localparam logic signed [C_EXP+2:0] c_SHIFT_LIM = (C_EXP+3)'(C_SHIFT_MAX);

  // ---------------------------------------------------------------- datapath
  logic signed [C_EXP+2:0] w_exp_prod_ext;
  logic signed [C_EXP+2:0] w_exp_diff;
  logic signed [C_EXP+2:0] w_shift_raw;
  logic [C_SHIFT_W-1:0]    w_shift;
  logic                    w_sign_prod;
  logic                    w_sub;
  logic                    w_special;
  logic [C_EXP+C_MANT:0]   w_special_res;
  logic                    w_nv;
  align_res_t              w_new;
  logic                    w_unused_den;

  // Denormal exponents arrive already forced to 1, so the flags carry no
  // extra information for this stage.
  assign w_unused_den = in_bus.DeN_a_SI ^ in_bus.DeN_b_SI ^ in_bus.DeN_c_SI;

  assign w_exp_prod_ext = $signed({3'b000, in_bus.Exp_a_DI}) +
                          $signed({3'b000, in_bus.Exp_b_DI}) - c_BIAS_EXT;
  assign w_exp_diff     = w_exp_prod_ext - $signed({3'b000, in_bus.Exp_c_DI});
  // Addend starts C_MANT+3 places left of the product so that a zero offset
  // still leaves guard room; clamp to the window of the wide adder.
  assign w_shift_raw    = w_exp_diff + c_SHIFT_OFF;

  always_comb begin
    if (w_shift_raw[C_EXP+2]) begin
      w_shift = '0;
    end else if (w_shift_raw > c_SHIFT_LIM) begin
      w_shift = C_SHIFT_W'(C_SHIFT_MAX);
    end else begin
      w_shift = w_shift_raw[C_SHIFT_W-1:0];
    end
  end

  assign w_sign_prod = in_bus.Sign_a_DI ^ in_bus.Sign_b_DI;
  assign w_sub       = w_sign_prod ^ in_bus.Sign_c_DI;

  fmac_special_case u_special (
    .i_sign_prod   (w_sign_prod),
    .i_sign_c      (in_bus.Sign_c_DI),
    .i_sub         (w_sub),
    .i_inf_a       (in_bus.Inf_a_SI),
    .i_inf_b       (in_bus.Inf_b_SI),
    .i_inf_c       (in_bus.Inf_c_SI),
    .i_zero_a      (in_bus.Zero_a_SI),
    .i_zero_b      (in_bus.Zero_b_SI),
    .i_zero_c      (in_bus.Zero_c_SI),
    .i_nan_a       (in_bus.NaN_a_SI),
    .i_nan_b       (in_bus.NaN_b_SI),
    .i_nan_c       (in_bus.NaN_c_SI),
    .i_quiet_a     (in_bus.Mant_a_DI[C_MANT-1]),
    .i_quiet_b     (in_bus.Mant_b_DI[C_MANT-1]),
    .i_quiet_c     (in_bus.Mant_c_DI[C_MANT-1]),
    .o_special     (w_special),
    .o_special_res (w_special_res),
    .o_nv          (w_nv)
  );

  always_comb begin
    w_new             = '0;
    w_new.mant_a      = in_bus.Mant_a_DI;
    w_new.mant_b      = in_bus.Mant_b_DI;
    w_new.mant_c      = in_bus.Mant_c_DI;
    w_new.exp_prod    = w_exp_prod_ext[C_EXP+1:0];
    w_new.shift       = w_shift;
    w_new.sign_prod   = w_sign_prod;
    w_new.sign_c      = in_bus.Sign_c_DI;
    w_new.sub         = w_sub;
    w_new.special     = w_special;
    w_new.special_res = w_special_res;
    w_new.nv          = w_nv;
  end

  // ------------------------------------------------------------ buffer/FSM
  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  align_res_t r_main;
  logic       w_ready;
  logic       w_valid;
  logic       w_accept;
  logic       w_drain;

  assign w_valid  = (r_state != c_ST_EMPTY);
  assign w_accept = in_bus.Valid_SI & w_ready;
  assign w_drain  = w_valid & out_bus.Ready_SI;

`ifdef FMAC_ALIGN_SKID_EN
  align_res_t r_skid;
  logic       r_ready;

  // Ready comes from a flop so the downstream ready never reaches upstream
  // combinationally; the skid entry absorbs the one op that slips through.
  assign w_ready = r_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_EMPTY: if (w_accept) w_state_nxt = c_ST_BUSY;
      c_ST_BUSY: begin
        if (w_accept && !w_drain)      w_state_nxt = c_ST_FULL;
        else if (!w_accept && w_drain) w_state_nxt = c_ST_EMPTY;
      end
      c_ST_FULL:  if (w_drain) w_state_nxt = c_ST_BUSY;
      default:    w_state_nxt = c_ST_EMPTY;
    endcase
    if (Flush_SI) w_state_nxt = c_ST_EMPTY;
  end

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      r_state <= c_ST_EMPTY;
      r_ready <= 1'b1;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt != c_ST_FULL);
      if (!Flush_SI) begin
        case (r_state)
          c_ST_EMPTY: if (w_accept) r_main <= w_new;
          c_ST_BUSY: begin
            if (w_accept && w_drain) r_main <= w_new;
            else if (w_accept)       r_skid <= w_new;
          end
          c_ST_FULL:  if (w_drain) r_main <= r_skid;
          default: ;
        endcase
      end
    end
  end
`else
  assign w_ready = ~w_valid | out_bus.Ready_SI;

  always_comb begin
    w_state_nxt = r_state;
    if (Flush_SI)      w_state_nxt = c_ST_EMPTY;
    else if (w_accept) w_state_nxt = c_ST_BUSY;
    else if (w_drain)  w_state_nxt = c_ST_EMPTY;
  end

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      r_state <= c_ST_EMPTY;
      r_main  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (!Flush_SI && w_accept) r_main <= w_new;
    end
  end
`endif

  // ---------------------------------------------------------------- outputs
  assign in_bus.Ready_SO        = w_ready;
  assign out_bus.Valid_SO       = w_valid;
  assign out_bus.Mant_a_DO      = r_main.mant_a;
  assign out_bus.Mant_b_DO      = r_main.mant_b;
  assign out_bus.Mant_c_DO      = r_main.mant_c;
  assign out_bus.Exp_prod_DO    = r_main.exp_prod;
  assign out_bus.Shift_DO       = r_main.shift;
  assign out_bus.Sign_prod_DO   = r_main.sign_prod;
  assign out_bus.Sign_c_DO      = r_main.sign_c;
  assign out_bus.Sub_SO         = r_main.sub;
  assign out_bus.Special_SO     = r_main.special;
  assign out_bus.Special_res_DO = r_main.special_res;
  assign out_bus.NV_SO          = r_main.nv;

endmodule
`default_nettype wire

// File: tb/tb_fmac_align_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fmac_align_stage                                           |
// | Purpose  : Self-checking bench for fmac_align_stage. Operands are IEEE   |
// |            single words unpacked here; expected records come from an     |
// |            arithmetic/IEEE reference and a queue of in-flight ops.       |
// | Config   : honours FMAC_ALIGN_SKID_EN for buffer depth and ready rule.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_fmac_align_stage;
  import fmac_align_stage_pkg::*;

  typedef logic [125:0] vec_t;

`ifdef FMAC_ALIGN_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  fmac_align_in_if  u_in ();
  fmac_align_out_if u_out ();

  fmac_align_stage dut (
    .Clk_CI   (clk),
    .Rst_RI   (rst),
    .Flush_SI (flush),
    .in_bus   (u_in),
    .out_bus  (u_out)
  );

  int          n_vec = 0;
  int          n_err = 0;
  vec_t        q[$];
  logic [31:0] cur_a, cur_b, cur_c;

  // ---------------------------------------------------------- IEEE helpers
  function automatic bit f_nan(logic [31:0] w);
    return (w[30:23] == 8'hFF) && (w[22:0] != 0);
  endfunction
  function automatic bit f_inf(logic [31:0] w);
    return (w[30:23] == 8'hFF) && (w[22:0] == 0);
  endfunction
  function automatic bit f_zero(logic [31:0] w);
    return w[30:0] == 0;
  endfunction
  function automatic bit f_den(logic [31:0] w);
    return (w[30:23] == 0) && (w[22:0] != 0);
  endfunction
  function automatic int f_exp(logic [31:0] w);
    return (w[30:23] == 0) ? 1 : int'(w[30:23]);
  endfunction
  function automatic logic [23:0] f_mant(logic [31:0] w);
    return {w[30:23] != 0, w[22:0]};
  endfunction

  // Expected record for a*b+c.
  function automatic vec_t ref_model(logic [31:0] a, logic [31:0] b, logic [31:0] c);
    int ep, sh;
    bit sp, sc, sub, spec, nv;
    logic [31:0] res;
    ep  = f_exp(a) + f_exp(b) - 127;
    sh  = ep - f_exp(c) + 26;
    if (sh < 0)  sh = 0;
    if (sh > 74) sh = 74;
    sp  = a[31] ^ b[31];
    sc  = c[31];
    sub = (sp != sc);
    spec = 1'b1;
    nv   = 1'b0;
    res  = 32'h0;
    if (f_nan(a) || f_nan(b) || f_nan(c)) begin
      res = 32'h7FC00000;
      nv  = (f_nan(a) && !a[22]) || (f_nan(b) && !b[22]) || (f_nan(c) && !c[22]);
    end else if ((f_inf(a) && f_zero(b)) || (f_zero(a) && f_inf(b))) begin
      res = 32'h7FC00000; nv = 1'b1;
    end else if (f_inf(a) || f_inf(b)) begin
      if (f_inf(c) && sub) begin res = 32'h7FC00000; nv = 1'b1; end
      else res = {sp, 8'hFF, 23'h0};
    end else if (f_inf(c)) begin
      res = {sc, 8'hFF, 23'h0};
    end else if ((f_zero(a) || f_zero(b)) && f_zero(c)) begin
      res = {sp && sc, 31'h0};
    end else begin
      spec = 1'b0;
    end
    return {f_mant(a), f_mant(b), f_mant(c), 10'(ep), 7'(sh), sp, sc, sub, spec, res, nv};
  endfunction

  function automatic vec_t dut_vec();
    return {u_out.Mant_a_DO, u_out.Mant_b_DO, u_out.Mant_c_DO, u_out.Exp_prod_DO,
            u_out.Shift_DO, u_out.Sign_prod_DO, u_out.Sign_c_DO, u_out.Sub_SO,
            u_out.Special_SO, u_out.Special_res_DO, u_out.NV_SO};
  endfunction

  function automatic logic [31:0] rand_op();
    int k;
    logic s;
    k = $urandom_range(0, 11);
    s = 1'($urandom_range(0, 1));
    case (k)
      0:       return {s, 31'h0};
      1:       return {s, 8'hFF, 23'h0};
      2:       return {s, 8'hFF, 1'b1, 22'($urandom)};
      3:       return {s, 8'hFF, 1'b0, 22'($urandom) | 22'h1};
      4:       return {s, 8'h00, 23'($urandom) | 23'h1};
      default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
    endcase
  endfunction

  // -------------------------------------------------------------- checking
  task automatic chk(input string tag, input vec_t obs, input vec_t expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic set_ops(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic v);
    cur_a = a; cur_b = b; cur_c = c;
    u_in.Valid_SI  = v;
    u_in.Sign_a_DI = a[31];  u_in.Sign_b_DI = b[31];  u_in.Sign_c_DI = c[31];
    u_in.Exp_a_DI  = 8'(f_exp(a)); u_in.Exp_b_DI = 8'(f_exp(b)); u_in.Exp_c_DI = 8'(f_exp(c));
    u_in.Mant_a_DI = f_mant(a); u_in.Mant_b_DI = f_mant(b); u_in.Mant_c_DI = f_mant(c);
    u_in.Inf_a_SI  = f_inf(a);  u_in.Inf_b_SI  = f_inf(b);  u_in.Inf_c_SI  = f_inf(c);
    u_in.Zero_a_SI = f_zero(a); u_in.Zero_b_SI = f_zero(b); u_in.Zero_c_SI = f_zero(c);
    u_in.NaN_a_SI  = f_nan(a);  u_in.NaN_b_SI  = f_nan(b);  u_in.NaN_c_SI  = f_nan(c);
    u_in.DeN_a_SI  = f_den(a);  u_in.DeN_b_SI  = f_den(b);  u_in.DeN_c_SI  = f_den(c);
  endtask

  // One clock: check outputs against the model, advance the model with the
  // handshake outcome, then move to the next falling edge.
  task automatic cycle();
    bit exp_ready, acc, drn;
    #1;
    exp_ready = SKID ? (q.size() < 2) : (q.size() == 0 || u_out.Ready_SI);
    chk("ready", vec_t'(u_in.Ready_SO), vec_t'(exp_ready));
    chk("valid", vec_t'(u_out.Valid_SO), vec_t'(q.size() != 0));
    if (q.size() != 0) chk("data", dut_vec(), q[0]);
    acc = u_in.Valid_SI && exp_ready;
    drn = (q.size() != 0) && u_out.Ready_SI;
    if (flush) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(ref_model(cur_a, cur_b, cur_c));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    set_ops(a, b, c, 1'b1);
    cycle();
    u_in.Valid_SI = 1'b0;
    #1;
  endtask

  task automatic spot(input string tag, input logic special, input logic [31:0] res,
                      input logic nv);
    chk({tag, "_special"}, vec_t'(u_out.Special_SO), vec_t'(special));
    chk({tag, "_res"}, vec_t'(u_out.Special_res_DO), vec_t'(res));
    chk({tag, "_nv"}, vec_t'(u_out.NV_SO), vec_t'(nv));
  endtask

  // ------------------------------------------------------------- stimulus
  initial begin
    rst = 1'b1;
    flush = 1'b0;
    u_out.Ready_SI = 1'b1;
    set_ops(32'h0, 32'h0, 32'h0, 1'b0);
    #2;
    chk("rst_ready", vec_t'(u_in.Ready_SO), vec_t'(1'b1));
    chk("rst_valid", vec_t'(u_out.Valid_SO), vec_t'(1'b0));
    chk("rst_data", dut_vec(), '0);
    @(negedge clk);
    rst = 1'b0;

    // Directed operations, each sent alone with the sink ready.
    send(32'h3F800000, 32'h40000000, 32'h3F800000);
    chk("basic_valid", vec_t'(u_out.Valid_SO), vec_t'(1'b1));
    chk("basic_exp", vec_t'(u_out.Exp_prod_DO), vec_t'(10'd128));
    chk("basic_shift", vec_t'(u_out.Shift_DO), vec_t'(7'd27));
    chk("basic_sub", vec_t'(u_out.Sub_SO), vec_t'(1'b0));
    spot("basic", 1'b0, 32'h0, 1'b0);
    cycle();
    send(32'h7F800000, 32'h00000000, 32'h3F800000); spot("infx0", 1'b1, 32'h7FC00000, 1'b1); cycle();
    send(32'h7F800001, 32'h3F800000, 32'h3F800000); spot("snan", 1'b1, 32'h7FC00000, 1'b1); cycle();
    send(32'h7FC00001, 32'h3F800000, 32'h3F800000); spot("qnan", 1'b1, 32'h7FC00000, 1'b0); cycle();
    send(32'h7F800000, 32'h3F800000, 32'hFF800000); spot("inf_sub", 1'b1, 32'h7FC00000, 1'b1); cycle();
    send(32'h7F800000, 32'h3F800000, 32'h7F800000); spot("inf_add", 1'b1, 32'h7F800000, 1'b0); cycle();
    send(32'h80000000, 32'h3F800000, 32'h00000000); spot("zero", 1'b1, 32'h00000000, 1'b0); cycle();
    send(32'h00800000, 32'h00800000, 32'h7F000000);
    chk("shift_lo", vec_t'(u_out.Shift_DO), vec_t'(7'd0));
    cycle();
    send(32'h7F000000, 32'h7F000000, 32'h00800000);
    chk("shift_hi", vec_t'(u_out.Shift_DO), vec_t'(7'd74));
    cycle();

    // Stalled sink: three ops offered, buffer fills, then drains in order.
    u_out.Ready_SI = 1'b0;
    set_ops(32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b1); cycle();
    set_ops(32'h40000000, 32'h40400000, 32'hC0800000, 1'b1); cycle();
    set_ops(32'h40A00000, 32'hC0C00000, 32'h40E00000, 1'b1); cycle();
    #1;
    chk("stall_ready", vec_t'(u_in.Ready_SO), vec_t'(1'b0));
    chk("stall_depth", vec_t'(q.size()), vec_t'(SKID ? 2 : 1));
    u_in.Valid_SI = 1'b0;
    u_out.Ready_SI = 1'b1;
    repeat (3) cycle();
    #1;
    chk("drain_ready", vec_t'(u_in.Ready_SO), vec_t'(1'b1));
    chk("drain_valid", vec_t'(u_out.Valid_SO), vec_t'(1'b0));

    // Flush while full with a new op offered in the same cycle.
    u_out.Ready_SI = 1'b0;
    repeat (3) begin set_ops(rand_op(), rand_op(), rand_op(), 1'b1); cycle(); end
    flush = 1'b1;
    set_ops(rand_op(), rand_op(), rand_op(), 1'b1);
    cycle();
    flush = 1'b0;
    u_in.Valid_SI = 1'b0;
    #1;
    chk("flush_valid", vec_t'(u_out.Valid_SO), vec_t'(1'b0));
    chk("flush_ready", vec_t'(u_in.Ready_SO), vec_t'(1'b1));
    u_out.Ready_SI = 1'b1;
    repeat (3) cycle();

    // Random traffic with random back-pressure and occasional flushes.
    for (int i = 0; i < 400; i++) begin
      set_ops(rand_op(), rand_op(), rand_op(), 1'($urandom_range(0, 9) < 7));
      u_out.Ready_SI = 1'($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 49) == 0);
      cycle();
    end
    flush = 1'b0;

    // Asynchronous reset between clock edges with ops in flight.
    u_out.Ready_SI = 1'b0;
    repeat (2) begin set_ops(rand_op(), rand_op(), rand_op(), 1'b1); cycle(); end
    u_in.Valid_SI = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", vec_t'(u_out.Valid_SO), vec_t'(1'b0));
    chk("arst_ready", vec_t'(u_in.Ready_SO), vec_t'(1'b1));
    chk("arst_data", dut_vec(), '0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    u_out.Ready_SI = 1'b1;
    send(32'h3F800000, 32'h40000000, 32'h3F800000);
    repeat (2) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
